collision_unit: RTL and testbench
=================================

COLLISION_UNIT -- requirements
Module: collision_unit

Interface
REQ-001 CLOCK_50  in  1  sole clock; all state changes on rising edge.
REQ-002 RESET_N  in  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
REQ-003 RUN_COLLISION  in  1  level request from position controller; held high until it samples COLLISION_DONE.
REQ-004 CUR_ADDR  in  2  entity-file index of the mover; CUR_ID  in  2  mover ID (00 player, 01 enemy).
REQ-005 OLD_X  in  10 / OLD_Y  in  9  mover position before motion; PROJ_X  in  10 / PROJ_Y  in  9  projected position.
REQ-006 ENT_COUNT  in  3  number of valid entity-file entries (0..4).
REQ-007 RD_ADDR  out  2  entity-file read address; ENT_ID  in  2, ENT_X  in  10, ENT_Y  in  9  read data, valid one cycle after RD_ADDR.
REQ-008 COLLISION_DONE  out  1  one-cycle done pulse.
REQ-009 RES_X  out  10 / RES_Y  out  9  resolved position for buffer load.
REQ-010 GAME_OVER_FLAG  out  1 / YOU_WIN_FLAG  out  1  one-cycle event pulses, coincident with COLLISION_DONE.

Function
REQ-011 States: IDLE, FETCH, CMP, REPORT, HOLD.
REQ-012 IDLE: RUN_COLLISION=1 -> latch CUR_*, OLD_*, PROJ_*, ENT_COUNT; clear idx, blocked, hit_enemy, hit_goal; go FETCH, or REPORT if ENT_COUNT=0.
REQ-013 FETCH: drive RD_ADDR=idx[1:0]; go CMP.
REQ-014 CMP: evaluate ENT_* against latched data; idx++; go REPORT if idx+1=ENT_COUNT, else FETCH.
REQ-015 Scan latency: COLLISION_DONE asserts exactly 1+2*ENT_COUNT cycles after the IDLE cycle sampling RUN_COLLISION.
REQ-016 Overlap: 16x16 boxes; hit iff |PROJ_X-ENT_X|<16 and |PROJ_Y-ENT_Y|<16, differences computed one bit wider than the operand, no wrap.
REQ-017 Entry with idx=CUR_ADDR is skipped (no flag set).
REQ-018 On hit: ENT_ID=11 (wall) -> blocked; ENT_ID=01 and CUR_ID=00 -> hit_enemy; ENT_ID=01 and CUR_ID=01 -> blocked; ENT_ID=10 and CUR_ID=00 -> hit_goal; ENT_ID=00 and CUR_ID=01 -> hit_enemy; all other pairs ignored.
REQ-019 blocked, hit_enemy, hit_goal are sticky for the whole scan.
REQ-020 REPORT: COLLISION_DONE=1; RES_X/RES_Y registered = OLD if blocked, else PROJ; GAME_OVER_FLAG=hit_enemy; YOU_WIN_FLAG=hit_goal and not hit_enemy; go HOLD.
REQ-021 HOLD: remain while RUN_COLLISION=1; return to IDLE when RUN_COLLISION=0; no re-trigger from a held request.
REQ-022 RES_X/RES_Y hold value until next REPORT; RD_ADDR holds last value outside FETCH.
REQ-023 Input changes during FETCH/CMP ignored except ENT_*.

Reset
REQ-024 RESET_N=0 at any time, including mid-scan -> state IDLE, idx/sticky flags cleared, RD_ADDR=0, RES_X=0, RES_Y=0, COLLISION_DONE=0, both event flags=0, immediately without clock.
REQ-025 First RUN_COLLISION after reset release starts a full, fresh scan.

Configuration
REQ-026 Macro COLLISION_WALL_CLAMP_EN.
REQ-027 Defined: non-blocked result clamped to RES_X<=624, RES_Y<=464 (screen 640x480 minus sprite size); blocked result = OLD, unclamped.
REQ-028 Undefined: no clamp; non-blocked result = PROJ unchanged; latency identical either way.

Verification
REQ-029 ENT_COUNT=0, PROJ=(100,50) -> DONE 1 cycle after request, RES=(100,50), no flags.
REQ-030 Player CUR_ADDR=0 PROJ=(100,100) OLD=(96,100); entry1 wall at (110,105), ENT_COUNT=2 -> DONE at cycle 5, RES=(96,100), no flags.
REQ-031 Player PROJ=(200,200); entry2 enemy at (215,185), entry3 goal at (200,200), ENT_COUNT=4 -> DONE at cycle 9, GAME_OVER_FLAG=1, YOU_WIN_FLAG=0, RES=(200,200).
REQ-032 Enemy at (16,0) exactly 16 apart in X from player at (0,0) -> no hit; at (15,0) -> GAME_OVER_FLAG=1.
REQ-033 With COLLISION_WALL_CLAMP_EN, PROJ=(700,470), no hits -> RES=(624,464); without -> RES=(700,470).
REQ-034 RESET_N pulsed low in CMP of a 4-entry scan -> outputs zero at once, no DONE; new request gives DONE 9 cycles later.

Source files
------------

// File: rtl/collision_unit.sv
// Collision unit: scans the entity file for 16x16 box overlaps of a mover's projected position and resolves it.
// Latency: COLLISION_DONE 1+2*N cycles after the IDLE cycle that samples RUN_COLLISION (N = entity count).
// Backpressure: level request/done handshake; the request must drop before a new scan can start.
// Optional feature: define COLLISION_WALL_CLAMP_EN to clamp non-blocked results to the 640x480 playfield.
module collision_unit (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       RUN_COLLISION,
  input  logic [1:0] CUR_ADDR,
  input  logic [1:0] CUR_ID,
  input  logic [9:0] OLD_X,
  input  logic [8:0] OLD_Y,
  input  logic [9:0] PROJ_X,
  input  logic [8:0] PROJ_Y,
  input  logic [2:0] ENT_COUNT,
  output logic [1:0] RD_ADDR,
  input  logic [1:0] ENT_ID,
  input  logic [9:0] ENT_X,
  input  logic [8:0] ENT_Y,
  output logic       COLLISION_DONE,
  output logic [9:0] RES_X,
  output logic [8:0] RES_Y,
  output logic       GAME_OVER_FLAG,
  output logic       YOU_WIN_FLAG
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    CMP    = 3'd2,
    REPORT = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [1:0] ID_PLAYER = 2'b00;
  localparam logic [1:0] ID_ENEMY  = 2'b01;
  localparam logic [1:0] ID_GOAL   = 2'b10;
  localparam logic [1:0] ID_WALL   = 2'b11;

  state_t     state, state_nxt;

  // Scan context captured at request time; mover inputs are ignored once the scan starts.
  logic [2:0] idx;
  logic [2:0] count_q;
  logic [1:0] cur_addr_q;
  logic [1:0] cur_id_q;
  logic [9:0] old_x_q;
  logic [8:0] old_y_q;
  logic [9:0] proj_x_q;
  logic [8:0] proj_y_q;

  // Sticky results accumulated over the scan.
  logic       blocked;
  logic       hit_enemy;
  logic       hit_goal;

  logic [1:0] rd_addr_q;
  logic [9:0] res_x_q;
  logic [8:0] res_y_q;

  // FSM handshake strobes.
  logic       scan_start;
  logic       report_go;
  logic [2:0] idx_inc;

  // Overlap and classification of the entry currently on ENT_*.
  logic [10:0] dx, adx;
  logic [9:0]  dy, ady;
  logic        hit;
  logic        set_blk, set_enemy, set_goal;

  // Result selection.
  logic [9:0] src_px, clamp_x, res_x_nxt;
  logic [8:0] src_py, clamp_y, res_y_nxt;
  logic       blk_fin;

  assign idx_inc = idx + 3'd1;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the REPORT-cycle outputs.
  always_comb begin
    state_nxt      = state;
    scan_start     = 1'b0;
    report_go      = 1'b0;
    COLLISION_DONE = 1'b0;
    GAME_OVER_FLAG = 1'b0;
    YOU_WIN_FLAG   = 1'b0;
    case (state)
      IDLE: begin
        if (RUN_COLLISION) begin
          scan_start = 1'b1;
          if (ENT_COUNT == 3'd0) begin
            state_nxt = REPORT;
            report_go = 1'b1;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        state_nxt = CMP;
      end
      CMP: begin
        if (idx_inc == count_q) begin
          state_nxt = REPORT;
          report_go = 1'b1;
        end else begin
          state_nxt = FETCH;
        end
      end
      REPORT: begin
        COLLISION_DONE = 1'b1;
        GAME_OVER_FLAG = hit_enemy;
        YOU_WIN_FLAG   = hit_goal & ~hit_enemy;
        state_nxt      = HOLD;
      end
      HOLD: begin
        // A request still held from the previous scan must not start another one.
        if (!RUN_COLLISION) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Box overlap: differences are one bit wider than the operands so far-apart entries never wrap into a hit.
  always_comb begin
    dx  = {1'b0, proj_x_q} - {1'b0, ENT_X};
    dy  = {1'b0, proj_y_q} - {1'b0, ENT_Y};
    adx = dx[10] ? (~dx + 11'd1) : dx;
    ady = dy[9]  ? (~dy + 10'd1) : dy;
    hit = (adx < 11'd16) && (ady < 10'd16) && (idx[1:0] != cur_addr_q);
  end

  // Interaction table between the mover and the entry it overlaps.
  always_comb begin
    set_blk   = 1'b0;
    set_enemy = 1'b0;
    set_goal  = 1'b0;
    if (hit) begin
      case (ENT_ID)
        ID_WALL: set_blk = 1'b1;
        ID_ENEMY: begin
          if (cur_id_q == ID_PLAYER)     set_enemy = 1'b1;
          else if (cur_id_q == ID_ENEMY) set_blk   = 1'b1;
        end
        ID_GOAL: begin
          if (cur_id_q == ID_PLAYER) set_goal = 1'b1;
        end
        ID_PLAYER: begin
          if (cur_id_q == ID_ENEMY) set_enemy = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Resolved position: for an empty scan it comes straight from the request inputs; otherwise from the
  // latched context, including the verdict of the final CMP cycle so it lines up with COLLISION_DONE.
  always_comb begin
    src_px  = (state == IDLE) ? PROJ_X : proj_x_q;
    src_py  = (state == IDLE) ? PROJ_Y : proj_y_q;
    blk_fin = (state == CMP) && (blocked || set_blk);
`ifdef COLLISION_WALL_CLAMP_EN
    clamp_x = (src_px > 10'd624) ? 10'd624 : src_px;
    clamp_y = (src_py > 9'd464)  ? 9'd464  : src_py;
`else
    clamp_x = src_px;
    clamp_y = src_py;
`endif
    res_x_nxt = blk_fin ? old_x_q : clamp_x;
    res_y_nxt = blk_fin ? old_y_q : clamp_y;
  end

  // Scan context, index, entity-file address and sticky flags.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      idx        <= 3'd0;
      count_q    <= 3'd0;
      cur_addr_q <= 2'd0;
      cur_id_q   <= 2'd0;
      old_x_q    <= 10'd0;
      old_y_q    <= 9'd0;
      proj_x_q   <= 10'd0;
      proj_y_q   <= 9'd0;
      blocked    <= 1'b0;
      hit_enemy  <= 1'b0;
      hit_goal   <= 1'b0;
      rd_addr_q  <= 2'd0;
    end else begin
      if (scan_start) begin
        idx        <= 3'd0;
        // The entity file has four slots; larger counts scan all four.
        count_q    <= (ENT_COUNT > 3'd4) ? 3'd4 : ENT_COUNT;
        cur_addr_q <= CUR_ADDR;
        cur_id_q   <= CUR_ID;
        old_x_q    <= OLD_X;
        old_y_q    <= OLD_Y;
        proj_x_q   <= PROJ_X;
        proj_y_q   <= PROJ_Y;
        blocked    <= 1'b0;
        hit_enemy  <= 1'b0;
        hit_goal   <= 1'b0;
        // The address only moves when a FETCH is about to happen.
        if (ENT_COUNT != 3'd0) rd_addr_q <= 2'd0;
      end
      if (state == CMP) begin
        idx       <= idx_inc;
        blocked   <= blocked   | set_blk;
        hit_enemy <= hit_enemy | set_enemy;
        hit_goal  <= hit_goal  | set_goal;
        if (!report_go) rd_addr_q <= idx_inc[1:0];
      end
    end
  end

  // Result register, loaded on entry to REPORT and held until the next report.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      res_x_q <= 10'd0;
      res_y_q <= 9'd0;
    end else if (report_go) begin
      res_x_q <= res_x_nxt;
      res_y_q <= res_y_nxt;
    end
  end

  assign RD_ADDR = rd_addr_q;
  assign RES_X   = res_x_q;
  assign RES_Y   = res_y_q;

endmodule

// File: tb/tb_collision_unit.sv
// Scoreboard bench for collision_unit: directed scans push expected results, a negedge monitor checks them.
// Latency is checked as posedges from request to the DONE pulse.
// The entity file is modelled as a one-cycle synchronous-read memory.
module tb_collision_unit;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       RUN_COLLISION;
  logic [1:0] CUR_ADDR, CUR_ID;
  logic [9:0] OLD_X, PROJ_X;
  logic [8:0] OLD_Y, PROJ_Y;
  logic [2:0] ENT_COUNT;
  logic [1:0] RD_ADDR;
  logic [1:0] ENT_ID;
  logic [9:0] ENT_X;
  logic [8:0] ENT_Y;
  logic       COLLISION_DONE;
  logic [9:0] RES_X;
  logic [8:0] RES_Y;
  logic       GAME_OVER_FLAG, YOU_WIN_FLAG;

  collision_unit dut (
    .CLOCK_50       (CLOCK_50),
    .RESET_N        (RESET_N),
    .RUN_COLLISION  (RUN_COLLISION),
    .CUR_ADDR       (CUR_ADDR),
    .CUR_ID         (CUR_ID),
    .OLD_X          (OLD_X),
    .OLD_Y          (OLD_Y),
    .PROJ_X         (PROJ_X),
    .PROJ_Y         (PROJ_Y),
    .ENT_COUNT      (ENT_COUNT),
    .RD_ADDR        (RD_ADDR),
    .ENT_ID         (ENT_ID),
    .ENT_X          (ENT_X),
    .ENT_Y          (ENT_Y),
    .COLLISION_DONE (COLLISION_DONE),
    .RES_X          (RES_X),
    .RES_Y          (RES_Y),
    .GAME_OVER_FLAG (GAME_OVER_FLAG),
    .YOU_WIN_FLAG   (YOU_WIN_FLAG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Entity file model.
  logic [1:0] m_id [4];
  logic [9:0] m_x  [4];
  logic [8:0] m_y  [4];

  always @(posedge CLOCK_50) begin
    ENT_ID <= m_id[RD_ADDR];
    ENT_X  <= m_x[RD_ADDR];
    ENT_Y  <= m_y[RD_ADDR];
  end

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int         lat;
    logic [9:0] x;
    logic [8:0] y;
    logic       go;
    logic       win;
  } exp_t;

  exp_t sb[$];
  int   start_cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expectation on every DONE pulse; flags must never fire outside DONE.
  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (COLLISION_DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - start_cyc, e.lat);
        chk("res_x", RES_X, e.x);
        chk("res_y", RES_Y, e.y);
        chk("game_over", GAME_OVER_FLAG, e.go);
        chk("you_win", YOU_WIN_FLAG, e.win);
      end
    end else begin
      chk("flag_without_done", {GAME_OVER_FLAG, YOU_WIN_FLAG}, 0);
    end
  end

  task automatic set_ent(input int i, input logic [1:0] id, input logic [9:0] x, input logic [8:0] y);
    m_id[i] = id;
    m_x[i]  = x;
    m_y[i]  = y;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_done"},    COLLISION_DONE, 0);
    chk({tag, "_rd_addr"}, RD_ADDR, 0);
    chk({tag, "_res_x"},   RES_X, 0);
    chk({tag, "_res_y"},   RES_Y, 0);
    chk({tag, "_go"},      GAME_OVER_FLAG, 0);
    chk({tag, "_win"},     YOU_WIN_FLAG, 0);
  endtask

  task automatic drive_req(input logic [1:0] ca, input logic [1:0] ci,
                           input logic [9:0] ox, input logic [8:0] oy,
                           input logic [9:0] px, input logic [8:0] py, input logic [2:0] n);
    CUR_ADDR  = ca;
    CUR_ID    = ci;
    OLD_X     = ox;
    OLD_Y     = oy;
    PROJ_X    = px;
    PROJ_Y    = py;
    ENT_COUNT = n;
  endtask

  // One full request/done handshake; inputs are scrambled after the request is sampled and the
  // request is held in HOLD for a few cycles to catch re-triggering.
  task automatic run_scan(input logic [1:0] ca, input logic [1:0] ci,
                          input logic [9:0] ox, input logic [8:0] oy,
                          input logic [9:0] px, input logic [8:0] py, input logic [2:0] n,
                          input logic [9:0] ex, input logic [8:0] ey, input logic eg, input logic ew);
    exp_t e;
    bit   seen;
    @(posedge CLOCK_50); #1;
    drive_req(ca, ci, ox, oy, px, py, n);
    e.lat = 1 + 2 * int'(n);
    e.x   = ex;
    e.y   = ey;
    e.go  = eg;
    e.win = ew;
    sb.push_back(e);
    start_cyc = cyc;
    RUN_COLLISION = 1'b1;
    @(posedge CLOCK_50); #1;
    drive_req(~ca, ~ci, ~ox, ~oy, ~px, ~py, ~n);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLOCK_50);
      seen = COLLISION_DONE;
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (3) @(posedge CLOCK_50);
    #1 RUN_COLLISION = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b1;
    RUN_COLLISION = 1'b0;
    drive_req(2'd0, 2'd0, 10'd0, 9'd0, 10'd0, 9'd0, 3'd0);
    for (int i = 0; i < 4; i++) set_ent(i, 2'd0, 10'd0, 9'd0);
    #2 RESET_N = 1'b0;
    #1 zero_chk("reset");
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50) RESET_N = 1'b1;

    // Empty scan: done one cycle after the request, projected position passes through.
    run_scan(2'd0, 2'd0, 10'd10, 9'd10, 10'd100, 9'd50, 3'd0, 10'd100, 9'd50, 1'b0, 1'b0);

    // Player blocked by a wall in entry 1; entry 0 is the player itself.
    set_ent(0, 2'b00, 10'd96, 9'd100);
    set_ent(1, 2'b11, 10'd110, 9'd105);
    run_scan(2'd0, 2'd0, 10'd96, 9'd100, 10'd100, 9'd100, 3'd2, 10'd96, 9'd100, 1'b0, 1'b0);

    // Four entries: own slot holds an overlapping wall (skipped), far wall, enemy at dx=15/dy=-15, goal.
    set_ent(0, 2'b11, 10'd200, 9'd200);
    set_ent(1, 2'b11, 10'd500, 9'd400);
    set_ent(2, 2'b01, 10'd215, 9'd185);
    set_ent(3, 2'b10, 10'd200, 9'd200);
    run_scan(2'd0, 2'd0, 10'd190, 9'd190, 10'd200, 9'd200, 3'd4, 10'd200, 9'd200, 1'b1, 1'b0);

    // Boundary distance: 16 apart is a miss, 15 apart is a hit.
    set_ent(0, 2'b01, 10'd16, 9'd0);
    run_scan(2'd1, 2'd0, 10'd0, 9'd0, 10'd0, 9'd0, 3'd1, 10'd0, 9'd0, 1'b0, 1'b0);
    set_ent(0, 2'b01, 10'd0, 9'd16);
    run_scan(2'd1, 2'd0, 10'd0, 9'd0, 10'd0, 9'd0, 3'd1, 10'd0, 9'd0, 1'b0, 1'b0);
    set_ent(0, 2'b01, 10'd15, 9'd0);
    run_scan(2'd1, 2'd0, 10'd0, 9'd0, 10'd0, 9'd0, 3'd1, 10'd0, 9'd0, 1'b1, 1'b0);

    // Off-screen projection with no hits.
`ifdef COLLISION_WALL_CLAMP_EN
    run_scan(2'd0, 2'd0, 10'd1, 9'd1, 10'd700, 9'd470, 3'd0, 10'd624, 9'd464, 1'b0, 1'b0);
`else
    run_scan(2'd0, 2'd0, 10'd1, 9'd1, 10'd700, 9'd470, 3'd0, 10'd700, 9'd470, 1'b0, 1'b0);
`endif

    // Blocked near the edge: result is the old position, never clamped.
    set_ent(0, 2'b11, 10'd640, 9'd470);
    run_scan(2'd1, 2'd0, 10'd630, 9'd470, 10'd640, 9'd470, 3'd1, 10'd630, 9'd470, 1'b0, 1'b0);

    // Overlapping wall in the mover's own slot is skipped.
    set_ent(0, 2'b11, 10'd600, 9'd20);
    set_ent(1, 2'b11, 10'd300, 9'd300);
    run_scan(2'd1, 2'd0, 10'd290, 9'd300, 10'd300, 9'd300, 3'd2, 10'd300, 9'd300, 1'b0, 1'b0);

    // Player reaches the goal alone.
    set_ent(0, 2'b10, 10'd40, 9'd70);
    run_scan(2'd3, 2'd0, 10'd48, 9'd60, 10'd50, 9'd60, 3'd1, 10'd50, 9'd60, 1'b0, 1'b1);

    // Enemy mover: hits player (game over), blocked by another enemy, goal ignored.
    set_ent(0, 2'b00, 10'd405, 9'd210);
    set_ent(1, 2'b01, 10'd395, 9'd195);
    set_ent(2, 2'b10, 10'd400, 9'd200);
    run_scan(2'd3, 2'd1, 10'd390, 9'd200, 10'd400, 9'd200, 3'd3, 10'd390, 9'd200, 1'b1, 1'b0);

    // Far walls whose narrow differences would wrap into a false hit.
    set_ent(0, 2'b11, 10'd1020, 9'd5);
    set_ent(1, 2'b11, 10'd5, 9'd508);
    run_scan(2'd3, 2'd0, 10'd0, 9'd5, 10'd5, 9'd5, 3'd2, 10'd5, 9'd5, 1'b0, 1'b0);

    // Reset in the second CMP of a four-entry scan: outputs clear at once and no DONE follows.
    set_ent(0, 2'b11, 10'd200, 9'd200);
    set_ent(1, 2'b11, 10'd500, 9'd400);
    set_ent(2, 2'b01, 10'd215, 9'd185);
    set_ent(3, 2'b10, 10'd200, 9'd200);
    @(posedge CLOCK_50); #1;
    drive_req(2'd0, 2'd0, 10'd190, 9'd190, 10'd200, 9'd200, 3'd4);
    RUN_COLLISION = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    #1 chk("rd_addr_pre_reset", RD_ADDR, 1);
    RESET_N = 1'b0;
    #1 zero_chk("midscan_reset");
    RUN_COLLISION = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #2 RESET_N = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    run_scan(2'd0, 2'd0, 10'd190, 9'd190, 10'd200, 9'd200, 3'd4, 10'd200, 9'd200, 1'b1, 1'b0);

    repeat (3) @(posedge CLOCK_50);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
